intdiv: RTL and testbench

Iterative unsigned integer divider, the inverse of `intmul`: given a `LOGA+LOGB`-bit product-width dividend and a `LOGB`-bit divisor, it recovers the `LOGA`-bit quotient and `LOGB`-bit remainder. It uses radix-2 restoring division and produces one quotient bit per cycle behind valid/ready handshakes on both sides. It sits next to `intmul` in the datapath and is used where a true quotient is needed, for example in Barrett constant generation and in checking reductions.

---
 rtl/intdiv_pkg.sv | 21 ++
 rtl/intdiv_if.sv | 26 ++
 rtl/intdiv_step.sv | 30 +++
 rtl/intdiv.sv | 152 +++++++++++++++
 tb/tb_intdiv.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intdiv_pkg.sv
// Shared types and helpers for the iterative restoring divider.
// The optional error check is controlled by INTDIV_ERR_CHECK_EN, left undefined by default.
package intdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } intdiv_state_t;

    // Cycles from operand acceptance to the first cycle with a valid result.
    function automatic int intdiv_lat(input int loga);
        return loga + 1;
    endfunction

    // Width of the step counter; it must hold loga-1.
    function automatic int intdiv_cnt_w(input int loga);
        return (loga > 1) ? $clog2(loga) : 1;
    endfunction

endpackage

// File: rtl/intdiv_if.sv
// Operand and result handshakes of the divider, grouped as one bundle.
// The slave modport is the divider side, the master modport the client side.
interface intdiv_if #(
    parameter int LOGA = 32,
    parameter int LOGB = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LOGA+LOGB-1:0]   N;
    logic [LOGB-1:0]        D;
    logic                   out_valid;
    logic                   out_ready;
    logic [LOGA-1:0]        Q;
    logic [LOGB-1:0]        R;
    logic                   err;

    modport master (
        output in_valid, N, D, out_ready,
        input  in_ready, out_valid, Q, R, err
    );

    modport slave (
        input  in_valid, N, D, out_ready,
        output in_ready, out_valid, Q, R, err
    );
endinterface

// File: rtl/intdiv_step.sv
// One radix-2 restoring division step: shift in a dividend bit, subtract the
// divisor when it fits. W is the partial-remainder width (divisor width + 1).
module intdiv_step #(
    parameter int W = 33
) (
    input  logic [W-1:0] p_i,
    input  logic         dbit_i,
    input  logic [W-2:0] d_i,
    output logic [W-1:0] p_o,
    output logic         q_o
);
    logic [W:0] t_s;
    logic       ge_s;

    assign t_s  = {p_i, dbit_i};
    assign ge_s = (t_s >= {2'b00, d_i});

    // The difference always fits W bits because the kept remainder stays below the divisor.
    always_comb begin
        p_o = t_s[W-1:0];
        q_o = 1'b0;
        if (ge_s) begin
            p_o = t_s[W-1:0] - {1'b0, d_i};
            q_o = 1'b1;
        end else begin
            p_o = t_s[W-1:0];
            q_o = 1'b0;
        end
    end
endmodule

// File: rtl/intdiv.sv
// Iterative unsigned divider: (LOGA+LOGB)-bit dividend / LOGB-bit divisor, one quotient bit per cycle.
// Define INTDIV_ERR_CHECK_EN to flag divide-by-zero / quotient overflow and short-cut to DONE.
module intdiv
    import intdiv_pkg::*;
#(
    parameter int LOGA = 32,
    parameter int LOGB = 32
) (
    input  logic    clk,
    input  logic    rst,
    intdiv_if.slave bus
);
    localparam int CW = intdiv_cnt_w(LOGA);
    localparam int PW = LOGB + 1;

    intdiv_state_t   state_q;
    intdiv_state_t   state_d;
    logic [PW-1:0]   p_q;
    logic [PW-1:0]   p_next_s;
    logic [LOGA-1:0] a_q;
    logic [LOGA-1:0] a_next_s;
    logic [LOGB-1:0] d_q;
    logic [CW-1:0]   cnt_q;
    logic [LOGA-1:0] q_q;
    logic [LOGB-1:0] r_q;
    logic            err_q;
    logic            q_bit_s;
    logic            err_det_s;
    logic            last_s;

`ifdef INTDIV_ERR_CHECK_EN
    // The quotient fits LOGA bits only when the dividend's top half is below the divisor.
    assign err_det_s = (bus.D == {LOGB{1'b0}}) || (bus.N[LOGA+LOGB-1:LOGA] >= bus.D);
`else
    assign err_det_s = 1'b0;
`endif

    assign last_s   = (cnt_q == {CW{1'b0}});
    assign a_next_s = {a_q[LOGA-2:0], q_bit_s};

    intdiv_step #(
        .W(PW)
    ) u_step (
        .p_i    (p_q),
        .dbit_i (a_q[LOGA-1]),
        .d_i    (d_q),
        .p_o    (p_next_s),
        .q_o    (q_bit_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = err_det_s ? DONE : BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE:    bus.in_ready  = 1'b1;
            BUSY:    bus.in_ready  = 1'b0;
            DONE:    bus.out_valid = 1'b1;
            default: bus.in_ready  = 1'b0;
        endcase
    end

    // Operand capture, iteration and result registers; the dividend shift register
    // doubles as the quotient accumulator, quotient bits entering at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q   <= {PW{1'b0}};
            a_q   <= {LOGA{1'b0}};
            d_q   <= {LOGB{1'b0}};
            cnt_q <= {CW{1'b0}};
            q_q   <= {LOGA{1'b0}};
            r_q   <= {LOGB{1'b0}};
            err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        p_q   <= {1'b0, bus.N[LOGA+LOGB-1:LOGA]};
                        a_q   <= bus.N[LOGA-1:0];
                        d_q   <= bus.D;
                        cnt_q <= CW'(LOGA - 1);
                        if (err_det_s) begin
                            q_q   <= {LOGA{1'b1}};
                            r_q   <= {LOGB{1'b0}};
                            err_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    p_q <= p_next_s;
                    a_q <= a_next_s;
                    if (last_s) begin
                        q_q   <= a_next_s;
                        r_q   <= p_next_s[LOGB-1:0];
                        err_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    cnt_q <= cnt_q;
                end
                default: begin
                    cnt_q <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.Q   = q_q;
    assign bus.R   = r_q;
    assign bus.err = err_q;

endmodule

// File: tb/tb_intdiv.sv
// Bench for intdiv: directed 8/8 cases plus randomized 32/17 operands, checked
// against an arithmetic reference model by a single per-cycle monitor.
module tb_intdiv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit rnd_done = 1'b0;

    intdiv_if #(.LOGA(8),  .LOGB(8))  if8  ();
    intdiv_if #(.LOGA(32), .LOGB(17)) if32 ();

    intdiv #(.LOGA(8),  .LOGB(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
    intdiv #(.LOGA(32), .LOGB(17)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic [63:0] n;
        logic [63:0] d;
        logic        e;
        logic        cq;
        logic        cr;
        int          lat;
        int          start;
    } exp_t;

    exp_t        eq0[$];
    exp_t        eq1[$];
    int          seen[2];
    int          rdy_due[2];
    int          done_cnt[2];
    logic [63:0] last_q[2];
    logic [63:0] last_r[2];
    logic        last_e[2];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Reference: plain integer division plus the error rules.
    function automatic exp_t model(input logic [63:0] n, input logic [63:0] d, input int la, input int st);
        exp_t        x;
        logic [63:0] mask;
        logic        ovf;
        mask    = (64'd1 << la) - 64'd1;
        ovf     = (d == 64'd0) || ((n >> la) >= d);
        x.n     = n;
        x.d     = d;
        x.start = st;
        x.lat   = la + 1;
        x.e     = 1'b0;
        x.cq    = 1'b1;
        x.cr    = 1'b1;
        if (d == 64'd0) begin
            x.q = mask;
            x.r = 64'd0;
        end else begin
            x.q = n / d;
            x.r = n % d;
        end
`ifdef INTDIV_ERR_CHECK_EN
        if (ovf) begin
            x.q   = mask;
            x.r   = 64'd0;
            x.e   = 1'b1;
            x.lat = 1;
        end
`else
        if (d == 64'd0) begin
            x.cr = 1'b0;
        end else if (ovf) begin
            x.cq = 1'b0;
            x.cr = 1'b0;
        end
`endif
        return x;
    endfunction

    task automatic mon(input int id, input int la, input logic iv, input logic ir, input logic ov,
                       input logic ordy, input logic [63:0] n, input logic [63:0] d,
                       input logic [63:0] q, input logic [63:0] r, input logic e);
        exp_t  x;
        int    depth;
        string p;
        p = (id == 0) ? "u8" : "u32";
        if (rst) begin
            if (id == 0) eq0.delete(); else eq1.delete();
            seen[id]    = 0;
            rdy_due[id] = -1;
            return;
        end
        if (rdy_due[id] == cyc) begin
            check({p, " in_ready after output handshake"}, 64'(ir), 64'd1);
            rdy_due[id] = -1;
        end
        depth = (id == 0) ? eq0.size() : eq1.size();
        if (ov) begin
            if (depth == 0) begin
                check({p, " spurious out_valid"}, 64'(ov), 64'd0);
            end else begin
                if (id == 0) x = eq0[0]; else x = eq1[0];
                if (seen[id] == 0) begin
                    check({p, " latency"}, 64'(cyc - x.start), 64'(x.lat));
                    seen[id] = 1;
                end
                check({p, " in_ready while out_valid"}, 64'(ir), 64'd0);
                check({p, " err"}, 64'(e), 64'(x.e));
                if (x.cq) check({p, " Q"}, q, x.q);
                if (x.cr) check({p, " R"}, r, x.r);
                if (id == 1 && !x.e && x.cq && x.cr) begin
                    check({p, " Q*D+R==N"}, q * x.d + r, x.n);
                    check({p, " R<D"}, 64'(r < x.d), 64'd1);
                end
                if (ordy) begin
                    if (id == 0) void'(eq0.pop_front()); else void'(eq1.pop_front());
                    seen[id]     = 0;
                    rdy_due[id]  = cyc + 1;
                    last_q[id]   = q;
                    last_r[id]   = r;
                    last_e[id]   = e;
                    done_cnt[id] = done_cnt[id] + 1;
                end
            end
        end
        if (iv && ir) begin
            if (id == 0) eq0.push_back(model(n, d, la, cyc));
            else         eq1.push_back(model(n, d, la, cyc));
        end
    endtask

    // Single compare process for both instances.
    always @(negedge clk) begin
        mon(0, 8, if8.in_valid, if8.in_ready, if8.out_valid, if8.out_ready,
            64'(if8.N), 64'(if8.D), 64'(if8.Q), 64'(if8.R), if8.err);
        mon(1, 32, if32.in_valid, if32.in_ready, if32.out_valid, if32.out_ready,
            64'(if32.N), 64'(if32.D), 64'(if32.Q), 64'(if32.R), if32.err);
    end

    task automatic send8(input logic [15:0] n, input logic [7:0] d);
        int k = 0;
        if8.N        = n;
        if8.D        = d;
        if8.in_valid = 1'b1;
        @(negedge clk);
        while (!if8.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!if8.in_ready) timeout_fail("u8 accept");
        @(posedge clk);
        #1 if8.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [48:0] n, input logic [16:0] d);
        int k = 0;
        if32.N        = n;
        if32.D        = d;
        if32.in_valid = 1'b1;
        @(negedge clk);
        while (!if32.in_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!if32.in_ready) timeout_fail("u32 accept");
        @(posedge clk);
        #1 if32.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int id, input int target);
        int k = 0;
        while (done_cnt[id] < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt[id] < target) timeout_fail("result wait");
    endtask

    task automatic run8(input string nm, input logic [15:0] n, input logic [7:0] d,
                        input logic [7:0] xq, input logic [7:0] xr, input logic xe, input logic cr);
        int c;
        c = done_cnt[0];
        send8(n, d);
        wait_done(0, c + 1);
        @(posedge clk);
        #1;
        check({nm, " Q"}, last_q[0], 64'(xq));
        if (cr) check({nm, " R"}, last_r[0], 64'(xr));
        check({nm, " err"}, 64'(last_e[0]), 64'(xe));
    endtask

    initial begin
        int          c;
        int          k;
        logic [63:0] n;
        logic [63:0] d;
        logic [63:0] qq;
        logic [63:0] rr;

        rdy_due[0]     = -1;
        rdy_due[1]     = -1;
        if8.in_valid   = 1'b0;
        if8.N          = '0;
        if8.D          = '0;
        if8.out_ready  = 1'b1;
        if32.in_valid  = 1'b0;
        if32.N         = '0;
        if32.D         = '0;
        if32.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst in_ready",     64'(if8.in_ready),  64'd1);
        check("rst out_valid",    64'(if8.out_valid), 64'd0);
        check("rst Q",            64'(if8.Q),         64'd0);
        check("rst R",            64'(if8.R),         64'd0);
        check("rst err",          64'(if8.err),       64'd0);
        check("rst u32 in_ready", 64'(if32.in_ready), 64'd1);
        @(posedge clk);
        #1;

        run8("3039/64", 16'h3039, 8'h64, 8'h7B, 8'h2D, 1'b0, 1'b1);
        run8("FE01/FF", 16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
        run8("00FE/01", 16'h00FE, 8'h01, 8'hFE, 8'h00, 1'b0, 1'b1);
`ifdef INTDIV_ERR_CHECK_EN
        run8("div0",    16'h1234, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1);
        run8("ovf",     16'h6400, 8'h64, 8'hFF, 8'h00, 1'b1, 1'b1);
`else
        run8("div0",    16'h1234, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
`endif

        // Back-pressure with a competing request held during the stall.
        if8.out_ready = 1'b0;
        c = done_cnt[0];
        send8(16'h3039, 8'h64);
        k = 0;
        @(negedge clk);
        while (!if8.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!if8.out_valid) timeout_fail("bp out_valid");
        @(posedge clk);
        #1;
        if8.N        = 16'h00FE;
        if8.D        = 8'h01;
        if8.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp in_ready",  64'(if8.in_ready),  64'd0);
            check("bp out_valid", 64'(if8.out_valid), 64'd1);
        end
        @(posedge clk);
        #1 if8.out_ready = 1'b1;
        @(negedge clk);
        check("bp handshake valid", 64'(if8.out_valid), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp accept after hs", 64'(if8.in_ready), 64'd1);
        check("bp held result Q",   last_q[0],         64'h7B);
        @(posedge clk);
        #1 if8.in_valid = 1'b0;
        wait_done(0, c + 2);
        @(posedge clk);
        #1;
        check("bp second Q", last_q[0], 64'hFE);
        check("bp second R", last_r[0], 64'h00);

        // Reset in cycle 4 of an operation.
        send8(16'h3039, 8'h64);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst out_valid", 64'(if8.out_valid), 64'd0);
        check("midrst in_ready",  64'(if8.in_ready),  64'd1);
        check("midrst Q",         64'(if8.Q),         64'd0);
        check("midrst R",         64'(if8.R),         64'd0);
        @(posedge clk);
        #1;
        run8("post-rst 3039/64", 16'h3039, 8'h64, 8'h7B, 8'h2D, 1'b0, 1'b1);

        // Randomized 32/17 operands with random consumer stalls.
        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    if ($urandom_range(0, 15) == 0) begin
                        d = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 131071));
                        n = {$urandom, $urandom} & ((64'd1 << 49) - 64'd1);
                    end else begin
                        d  = 64'($urandom_range(1, 131071));
                        qq = 64'($urandom);
                        rr = 64'($urandom) % d;
                        n  = qq * d + rr;
                    end
                    send32(n[48:0], d[16:0]);
                end
                k = 0;
                while (eq1.size() != 0 && k < 500) begin
                    @(negedge clk);
                    k++;
                end
                if (eq1.size() != 0) timeout_fail("u32 drain");
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 if32.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        if32.out_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
